// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants and byte-step function for encoder and checker
package crc_pkg;

    localparam int          CRC8_W    = 8;
    localparam logic [7:0]  CRC8_POLY = 8'h31;

    function automatic logic [CRC8_W-1:0] crc8_byte_step(input logic [CRC8_W-1:0] crc,
                                                         input logic [7:0]        data);
        logic [CRC8_W-1:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[CRC8_W-2:0], 1'b0} ^ ((c[CRC8_W-1] ^ data[i]) ? CRC8_POLY : '0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// rtl/crc8_byte_update.sv - one CRC-8 byte update, 8 MSB-first division steps unrolled
module crc8_byte_update
    import crc_pkg::*;
#(
    parameter logic [CRC8_W-1:0] POLY = CRC8_POLY
) (
    input  logic [CRC8_W-1:0] crc_in,
    input  logic [7:0]        data_in,
    output logic [CRC8_W-1:0] crc_out
);

    logic [CRC8_W-1:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            c = {c[CRC8_W-2:0], 1'b0} ^ ((c[CRC8_W-1] ^ data_in[i]) ? POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc8_rx_checker.sv
// rtl/crc8_rx_checker.sv - byte-serial CRC-8 frame checker with payload reassembly
module crc8_rx_checker
    import crc_pkg::*;
#(
    parameter int                DATA_BYTES = 4,
    parameter logic [CRC8_W-1:0] POLY       = CRC8_POLY,
    parameter int                ERR_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_clr,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    crc_ok,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int               CNT_W    = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES);
    localparam logic [0:0]       ST_RECV  = 1'b0;
    localparam logic [0:0]       ST_HOLD  = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [CRC8_W-1:0]       crc;
    logic [CRC8_W-1:0]       crc_next;
    logic [8*DATA_BYTES-1:0] payload;
    logic                    accept;

    assign in_ready = (state == ST_RECV);
    assign accept   = in_valid && in_ready;

    crc8_byte_update #(.POLY(POLY)) u_update (
        .crc_in  (crc),
        .data_in (in_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RECV;
            cnt       <= '0;
            crc       <= '0;
            payload   <= '0;
            data_out  <= '0;
            crc_ok    <= 1'b0;
            out_valid <= 1'b0;
            err_cnt   <= '0;
        end else if (sync_clr) begin
            // Abort drops the frame in flight and any undelivered word; error history survives.
            state     <= ST_RECV;
            cnt       <= '0;
            crc       <= '0;
            payload   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (accept) begin
                        if (cnt == LAST_CNT) begin
                            // CRC byte: residue over the whole frame decides pass/fail.
                            out_valid <= 1'b1;
                            crc_ok    <= (crc_next == '0);
                            data_out  <= payload;
                            cnt       <= '0;
                            crc       <= '0;
                            payload   <= '0;
                            state     <= ST_HOLD;
                            if (crc_next != '0 && err_cnt != '1) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                        end else begin
                            crc     <= crc_next;
                            payload <= {payload[8*DATA_BYTES-9:0], in_byte};
                            cnt     <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_RECV;
                    end
                end
                default: state <= ST_RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_rx_checker.sv
// tb/tb_crc8_rx_checker.sv - self-checking bench for crc8_rx_checker
module tb_crc8_rx_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_clr;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        crc_ok;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int deliveries = 0;
    int model_err = 0;

    typedef struct {
        logic [39:0] frame;
        logic [31:0] exp_data;
        logic        exp_ok;
        logic [15:0] exp_err;
    } vec_t;

    vec_t tbl[3];

    always #5 clk = ~clk;

    crc8_rx_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .crc_ok    (crc_ok),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    always @(negedge clk) begin
        if (rst_n && !sync_clr && out_valid && out_ready) deliveries++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Long division of (message * x^8) by x^8 + 0x31; remainder returned.
    function automatic logic [7:0] ref_rem(input logic [39:0] msg, input int nbytes);
        logic [8:0] g;
        logic [8:0] r;
        g = 9'h131;
        r = '0;
        for (int i = nbytes * 8 - 1; i >= -8; i--) begin
            r = {r[7:0], (i >= 0) ? msg[i] : 1'b0};
            if (r[8]) r = r ^ g;
        end
        return r[7:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f, input bit gaps);
        for (int i = 0; i < 5; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (i == 4 && !gaps) chk("pre_last_valid", 64'(out_valid), 64'd0);
            send_byte(f[39 - 8*i -: 8]);
        end
    endtask

    function automatic void model_frame(input logic [39:0] f);
        if (ref_rem(f, 5) != 8'h00 && model_err < 65535) model_err++;
    endfunction

    task automatic check_out(input string name, input logic [31:0] d, input logic ok, input logic [15:0] e);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"},  64'(data_out),  64'(d));
        chk({name, "_ok"},    64'(crc_ok),    64'(ok));
        chk({name, "_err"},   64'(err_cnt),   64'(e));
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("deliver_clears_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [39:0] f;
        logic [31:0] p;
        logic        stable;
        int          d0;

        tbl[0] = '{40'h00_00_00_01_31, 32'h0000_0001, 1'b1, 16'd0};
        tbl[1] = '{40'h00_00_00_80_7A, 32'h0000_0080, 1'b1, 16'd0};
        tbl[2] = '{40'h00_00_00_80_7B, 32'h0000_0080, 1'b0, 16'd1};

        rst_n = 1'b0; sync_clr = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data",      64'(data_out),  64'd0);
        chk("rst_crc_ok",    64'(crc_ok),    64'd0);
        chk("rst_err",       64'(err_cnt),   64'd0);

        for (int v = 0; v < 3; v++) begin
            send_frame(tbl[v].frame, 1'b0);
            model_frame(tbl[v].frame);
            check_out($sformatf("vec%0d", v), tbl[v].exp_data, tbl[v].exp_ok, tbl[v].exp_err);
            deliver();
        end

        // Back-to-back frames with a stalled consumer.
        send_frame(tbl[0].frame, 1'b0);
        model_frame(tbl[0].frame);
        check_out("b2b_a", 32'h1, 1'b1, 16'(model_err));
        d0 = deliveries;
        fork
            send_frame(tbl[1].frame, 1'b0);
            begin
                stable = 1'b1;
                repeat (10) begin
                    tick();
                    if (in_ready !== 1'b0 || data_out !== 32'h1 || out_valid !== 1'b1 || crc_ok !== 1'b1)
                        stable = 1'b0;
                end
                chk("hold_stable", 64'(stable), 64'd1);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        join
        model_frame(tbl[1].frame);
        check_out("b2b_b", 32'h80, 1'b1, 16'(model_err));
        deliver();
        chk("b2b_count", 64'(deliveries - d0), 64'd2);

        // Gappy input, then randomized frames against the division model.
        f = {32'h1234_5678, ref_rem(40'h12345678, 4)};
        send_frame(f, 1'b1);
        model_frame(f);
        check_out("gappy", 32'h1234_5678, 1'b1, 16'(model_err));
        deliver();
        for (int r = 0; r < 10; r++) begin
            p = $urandom;
            f = {p, ref_rem(40'(p), 4)};
            if ($urandom_range(0, 1)) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
            send_frame(f, 1'b1);
            model_frame(f);
            check_out($sformatf("rand%0d", r), p, ref_rem(f, 5) == 8'h00, 16'(model_err));
            deliver();
        end

        // sync_clr mid-frame, with a byte presented in the same cycle.
        for (int i = 0; i < 3; i++) send_byte(8'hA5);
        in_byte = 8'hFF; in_valid = 1'b1; sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        d0 = deliveries;
        send_frame(tbl[0].frame, 1'b0);
        check_out("clr_frame", 32'h1, 1'b1, 16'(model_err));
        deliver();
        chk("clr_count", 64'(deliveries - d0), 64'd1);

        // sync_clr during HOLD discards the pending word but keeps err_cnt.
        send_frame(tbl[2].frame, 1'b0);
        model_frame(tbl[2].frame);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        chk("clr_hold_valid", 64'(out_valid), 64'd0);
        chk("clr_hold_ready", 64'(in_ready),  64'd1);
        chk("clr_hold_err",   64'(err_cnt),   64'(model_err));

        // Async reset mid-frame and mid-HOLD.
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data",  64'(data_out),  64'd0);
        chk("rst_mid_err",   64'(err_cnt),   64'd0);
        model_err = 0;
        tick();
        rst_n = 1'b1;
        send_frame(tbl[2].frame, 1'b0);
        model_frame(tbl[2].frame);
        check_out("pre_rst_hold", 32'h80, 1'b0, 16'(model_err));
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        chk("rst_hold_data",  64'(data_out),  64'd0);
        chk("rst_hold_ok",    64'(crc_ok),    64'd0);
        chk("rst_hold_err",   64'(err_cnt),   64'd0);
        model_err = 0;
        tick();
        rst_n = 1'b1;
        send_frame(tbl[0].frame, 1'b0);
        check_out("post_rst", 32'h1, 1'b1, 16'd0);
        deliver();

        // Saturation of the error counter.
        force dut.err_cnt = 16'hFFFF;
        tick();
        release dut.err_cnt;
        chk("sat_forced", 64'(err_cnt), 64'hFFFF);
        send_frame(tbl[2].frame, 1'b0);
        check_out("sat_bad", 32'h80, 1'b0, 16'hFFFF);
        deliver();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
